// File: rtl/dstack_regfile.sv
// Shift-register data stack behind the stack-control decoder: registered top/second/third,
// combinational indexed read for rotate/copy, occupancy tracking and sticky error flags.
module dstack_regfile #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            movement,
  input  logic [WORD_WIDTH-1:0] next_top,
  input  logic                  rotate,
  input  logic [4:0]            rotate_addr,
  output logic [WORD_WIDTH-1:0] top,
  output logic [WORD_WIDTH-1:0] second,
  output logic [WORD_WIDTH-1:0] third,
  output logic [WORD_WIDTH-1:0] rotate_value,
  output logic [5:0]            depth,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [5:0] DEPTH_W    = 6'(DEPTH);
  localparam logic [1:0] MV_REPLACE = 2'b00;
  localparam logic [1:0] MV_PUSH    = 2'b01;
  localparam logic [1:0] MV_POP1    = 2'b10;
  localparam logic [1:0] MV_POP2    = 2'b11;

  logic [WORD_WIDTH-1:0] s_q [DEPTH];
  logic [WORD_WIDTH-1:0] s_d [DEPTH];
  logic [5:0]            depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) s_d[i] = s_q[i];
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    // Every operation writes the decoder's result into the top slot.
    s_d[0]  = next_top;
    if (rotate) begin
      if ({1'b0, rotate_addr} >= depth_q) unf_d = 1'b1;
      // Entries 1..a slide down one; an out-of-range address only rewrites the top.
      if (int'(rotate_addr) < DEPTH) begin
        for (int i = 1; i < DEPTH; i++) begin
          if (i <= int'(rotate_addr)) s_d[i] = s_q[i-1];
        end
      end
    end else begin
      case (movement)
        MV_REPLACE: begin
          if (depth_q == 6'd0) unf_d = 1'b1;
        end
        MV_PUSH: begin
          for (int i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
          if (depth_q < DEPTH_W) depth_d = depth_q + 6'd1;
          else                   ovf_d   = 1'b1;
        end
        MV_POP1: begin
          for (int i = 1; i < DEPTH - 1; i++) s_d[i] = s_q[i+1];
          s_d[DEPTH-1] = '0;
          if (depth_q >= 6'd2) depth_d = depth_q - 6'd1;
          else begin
            depth_d = 6'd0;
            unf_d   = 1'b1;
          end
        end
        MV_POP2: begin
          for (int i = 1; i < DEPTH - 2; i++) s_d[i] = s_q[i+2];
          s_d[DEPTH-2] = '0;
          s_d[DEPTH-1] = '0;
          if (depth_q >= 6'd3) depth_d = depth_q - 6'd2;
          else begin
            depth_d = 6'd0;
            unf_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) s_q[i] <= '0;
      depth_q <= 6'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) s_q[i] <= s_d[i];
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Reads only registered state, so there is no loop through the decoder's next_top.
  always_comb begin
    rotate_value = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(rotate_addr) == i) rotate_value = s_q[i];
    end
  end

  assign top       = s_q[0];
  assign second    = s_q[1];
  assign third     = s_q[2];
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/dstack_regfile.md
Name: dstack_regfile

Overview:
- Data-stack storage stage, directly downstream of the data-stack control decoder.
- Each cycle it consumes the decoder's movement, next_top, rotate and rotate_addr outputs and updates a shift-register stack.
- Presents registered top, second and third to the ALU/decoder.
- Presents a combinational rotate_value read (entry at rotate_addr) back to the decoder for rotate/copy instructions.
- Tracks occupancy and raises sticky overflow/underflow flags.

Parameters:
- WORD_WIDTH, 32, width of every stack entry.
- DEPTH, 32, number of entries; must be ≤ 32 and ≥ 3 (rotate_addr is 5 bits).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- movement  input  2  00 replace top, 01 push, 10 pop one, 11 pop two.
- next_top  input  WORD_WIDTH  value written to entry 0 this cycle.
- rotate  input  1  rotate entry rotate_addr to top.
- rotate_addr  input  5  entry index for rotate/copy read (0 = top).
- top  output  WORD_WIDTH  entry 0, registered.
- second  output  WORD_WIDTH  entry 1, registered.
- third  output  WORD_WIDTH  entry 2, registered.
- rotate_value  output  WORD_WIDTH  combinational read of entry rotate_addr; 0 if rotate_addr ≥ DEPTH.
- depth  output  6  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a push occurred at depth == DEPTH.
- underflow  output  1  sticky: an access needed more entries than were present.

Behaviour:
- Storage is s[0..DEPTH-1]; s[0] drives top, s[1] drives second, s[2] drives third.
- Reset (synchronous, checked before any other update): all s[i] = 0, depth = 0, overflow = 0, underflow = 0. Reset mid-operation discards that cycle's update.
- The upstream halt path produces movement = 00, rotate = 0, next_top = top. The block treats this as an ordinary replace, giving no net change. No separate hold input exists.
- Priority: rotate = 1 overrides movement; movement is ignored that cycle.
- movement 00: s[0] ← next_top; others unchanged; depth unchanged. If depth == 0, underflow ← 1 and depth stays 0.
- movement 01 (push, also copy):
  - s[0] ← next_top; s[i] ← s[i-1] for i = 1..DEPTH-1; old s[DEPTH-1] is lost.
  - If depth < DEPTH, depth + 1; otherwise depth stays DEPTH and overflow ← 1.
  - Copy is a push whose next_top is the decoder-selected rotate_value; the block does not distinguish it.
- movement 10 (pop one):
  - s[0] ← next_top; s[i] ← s[i+1] for i = 1..DEPTH-2; s[DEPTH-1] ← 0.
  - If depth ≥ 2, depth − 1. If depth < 2, underflow ← 1 and depth saturates at 0; the data shift is still performed.
- movement 11 (pop two):
  - s[0] ← next_top; s[i] ← s[i+2] for i = 1..DEPTH-3; s[DEPTH-2] and s[DEPTH-1] ← 0.
  - If depth ≥ 3, depth − 2. Otherwise underflow ← 1 and depth saturates at 0.
- rotate = 1, with a = rotate_addr:
  - s[0] ← next_top (the decoder supplies old s[a]); s[i] ← s[i-1] for 1 ≤ i ≤ a; s[i] unchanged for i > a; depth unchanged.
  - a = 0 degenerates to a replace.
  - If a ≥ depth, underflow ← 1 and the rotate is still performed on the raw contents.
  - If a ≥ DEPTH, only s[0] is written and underflow ← 1.
- rotate_value: purely combinational from the current s[] and rotate_addr; zero latency. It must not depend on this cycle's next_top, so no combinational loop exists through the decoder.
- Latency: every update is visible on top/second/third/depth one cycle after the inputs are sampled.
- overflow and underflow clear only on reset.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 (movement 01) -> top = 0x33, second = 0x22, third = 0x11, depth = 3, flags 0.
- From that state, movement 11 with next_top = 0x55 (add result) -> top = 0x55, second = 0, depth = 1; then movement 10 -> underflow = 1, depth = 0.
- Push 1..5, rotate_addr = 3 -> rotate_value = 2. Then rotate = 1, next_top = 2 -> stack top-down 2,5,4,3,1, depth = 5. Copy case: rotate_addr = 4, movement 01, next_top = rotate_value -> top = 1, depth = 6.
- Push DEPTH+1 values 1..33 -> depth = 32, overflow = 1, top = 33, s[31] = 2 (value 1 lost).
- Halt-equivalent input (movement 00, rotate 0, next_top = top) for 10 cycles -> all outputs unchanged.
- Assert reset in the same cycle as a push of 0xAA -> top = 0, depth = 0, flags cleared, 0xAA not stored.
